// File: rtl/monitor_uart_port.sv
// CPU-side UART port for the 68000 bus: TX/RX FIFOs behind a 4-register window,
// handing bytes to and from the SPI monitor bridge through trigger/busy and received/capture handshakes.
module monitor_uart_port #(
    parameter int unsigned FIFO_AW      = 4,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                MCLK_IN,
    input  logic                RESET_IN,
    input  logic                REG_RD_IN,
    input  logic                REG_WR_IN,
    input  logic [1:0]          REG_ADDR_IN,
    input  logic [7:0]          REG_WDATA_IN,
    output logic [7:0]          REG_RDATA,
    output logic                UART_IRQ,
    input  logic                UART_SEND_BUSY_IN,
    output logic                UART_SEND_TRIGGER,
    output logic [7:0]          UART_SEND_BYTE,
    input  logic                UART_RECEIVED_IN,
    input  logic [7:0]          UART_RECEIVE_BYTE_IN,
    output logic                UART_RECEIVE_CAPTURE
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned GW    = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [2:0] {T_IDLE, T_SETUP, T_STROBE, T_GUARD, T_WAIT} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LATCH, R_STROBE, R_GUARD} rx_state_t;

    tx_state_t          tx_state, tx_next;
    rx_state_t          rx_state, rx_next;
    logic [GW-1:0]      tx_gcnt, tx_gcnt_next, rx_gcnt, rx_gcnt_next;
    logic               busy_q, busy_s, rcv_q, rcv_s;
    logic [7:0]         tx_mem [DEPTH];
    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0]      tx_cnt, rx_cnt, tx_cnt_nxt, rx_cnt_nxt;
    logic               tx_ovf, rx_ovf, rx_stall_q;
    logic               tx_full, tx_empty, rx_full, rx_empty, tx_idle;
    logic               data_wr, stat_wr, data_rd;
    logic               tx_push, tx_pop, rx_push, rx_pop;
    logic               tx_ovf_set, rx_stall, rx_ovf_set;
    logic [7:0]         rdata_nxt;

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic push,
                                               input logic pop);
        if (push && !pop) return c + CW'(1);
        if (!push && pop) return c - CW'(1);
        return c;
    endfunction

    assign tx_full    = (tx_cnt == CW'(DEPTH));
    assign tx_empty   = (tx_cnt == '0);
    assign rx_full    = (rx_cnt == CW'(DEPTH));
    assign rx_empty   = (rx_cnt == '0);
    assign tx_idle    = tx_empty && (tx_state == T_IDLE);
    assign data_wr    = REG_WR_IN && (REG_ADDR_IN == 2'd0);
    assign stat_wr    = REG_WR_IN && (REG_ADDR_IN == 2'd1);
    assign data_rd    = REG_RD_IN && (REG_ADDR_IN == 2'd0);
    assign tx_push    = data_wr && !tx_full;
    assign tx_ovf_set = data_wr && tx_full;
    assign rx_push    = (rx_state == R_LATCH) && !rx_full;
    assign rx_pop     = data_rd && !rx_empty;
    // Monitor is holding a byte we cannot accept; flag only the first cycle of the stall.
    assign rx_stall   = (rx_state == R_IDLE) && rcv_s && rx_full;
    assign rx_ovf_set = rx_stall && !rx_stall_q;
    assign tx_cnt_nxt = cnt_next(tx_cnt, tx_push, tx_pop);
    assign rx_cnt_nxt = cnt_next(rx_cnt, rx_push, rx_pop);

    // TX handshake next-state
    always_comb begin
        tx_next      = tx_state;
        tx_gcnt_next = tx_gcnt;
        tx_pop       = 1'b0;
        case (tx_state)
            T_IDLE: if (!tx_empty && !busy_s) begin
                tx_pop  = 1'b1;
                tx_next = T_SETUP;
            end
            T_SETUP:  tx_next = T_STROBE;
            T_STROBE: begin
                tx_next      = T_GUARD;
                tx_gcnt_next = '0;
            end
            T_GUARD: begin
                if (tx_gcnt == GW'(GUARD_CYCLES - 1)) tx_next = T_WAIT;
                else tx_gcnt_next = tx_gcnt + GW'(1);
            end
            T_WAIT:  if (!busy_s) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    // RX handshake next-state
    always_comb begin
        rx_next      = rx_state;
        rx_gcnt_next = rx_gcnt;
        case (rx_state)
            R_IDLE:   if (rcv_s && !rx_full) rx_next = R_LATCH;
            R_LATCH:  rx_next = R_STROBE;
            R_STROBE: begin
                rx_next      = R_GUARD;
                rx_gcnt_next = '0;
            end
            R_GUARD: begin
                if (rx_gcnt == GW'(GUARD_CYCLES - 1)) rx_next = R_IDLE;
                else rx_gcnt_next = rx_gcnt + GW'(1);
            end
            default: rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        rdata_nxt = '0;
        case (REG_ADDR_IN)
            2'd0:    if (!rx_empty) rdata_nxt = rx_mem[rx_rd];
            2'd1:    rdata_nxt = {3'b000, tx_ovf, rx_ovf, tx_idle, !tx_full, !rx_empty};
            2'd2:    rdata_nxt = 8'(rx_cnt);
            default: rdata_nxt = 8'(tx_cnt);
        endcase
    end

    always_ff @(posedge MCLK_IN) begin
        if (tx_push) tx_mem[tx_wr] <= REG_WDATA_IN;
        if (rx_push) rx_mem[rx_wr] <= UART_RECEIVE_BYTE_IN;
    end

    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            tx_state             <= T_IDLE;
            rx_state             <= R_IDLE;
            tx_gcnt              <= '0;
            rx_gcnt              <= '0;
            busy_q               <= 1'b0;
            busy_s               <= 1'b0;
            rcv_q                <= 1'b0;
            rcv_s                <= 1'b0;
            tx_wr                <= '0;
            tx_rd                <= '0;
            rx_wr                <= '0;
            rx_rd                <= '0;
            tx_cnt               <= '0;
            rx_cnt               <= '0;
            tx_ovf               <= 1'b0;
            rx_ovf               <= 1'b0;
            rx_stall_q           <= 1'b0;
            REG_RDATA            <= '0;
            UART_IRQ             <= 1'b0;
            UART_SEND_TRIGGER    <= 1'b0;
            UART_SEND_BYTE       <= '0;
            UART_RECEIVE_CAPTURE <= 1'b0;
        end else begin
            tx_state             <= tx_next;
            rx_state             <= rx_next;
            tx_gcnt              <= tx_gcnt_next;
            rx_gcnt              <= rx_gcnt_next;
            busy_q               <= UART_SEND_BUSY_IN;
            busy_s               <= busy_q;
            rcv_q                <= UART_RECEIVED_IN;
            rcv_s                <= rcv_q;
            if (tx_push) tx_wr <= tx_wr + FIFO_AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + FIFO_AW'(1);
            if (rx_push) rx_wr <= rx_wr + FIFO_AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + FIFO_AW'(1);
            tx_cnt               <= tx_cnt_nxt;
            rx_cnt               <= rx_cnt_nxt;
            tx_ovf               <= tx_ovf_set || (tx_ovf && !(stat_wr && REG_WDATA_IN[4]));
            rx_ovf               <= rx_ovf_set || (rx_ovf && !(stat_wr && REG_WDATA_IN[3]));
            rx_stall_q           <= rx_stall;
            if (REG_RD_IN) REG_RDATA <= rdata_nxt;
            UART_IRQ             <= (rx_cnt_nxt != '0);
            if (tx_pop) UART_SEND_BYTE <= tx_mem[tx_rd];
            UART_SEND_TRIGGER    <= (tx_next == T_STROBE);
            UART_RECEIVE_CAPTURE <= (rx_next == R_STROBE);
        end
    end

endmodule

// File: tb/tb_monitor_uart_port.sv
// Scoreboard bench for monitor_uart_port: TX bytes queued on CPU write and checked on each
// trigger edge; RX bytes queued when Monitor offers them and checked on CPU DATA reads.
module tb_monitor_uart_port;

    logic       clk = 1'b0;
    logic       rst, rd, wr, busy, received;
    logic [1:0] addr;
    logic [7:0] wdata, rx_byte;
    logic [7:0] rdata, sbyte;
    logic       irq, trig, capture;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int trig_count = 0;
    int cap_count  = 0;
    int last_trig  = 0;
    int prev_trig  = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    monitor_uart_port #(.FIFO_AW(4), .GUARD_CYCLES(4)) dut (
        .MCLK_IN(clk), .RESET_IN(rst), .REG_RD_IN(rd), .REG_WR_IN(wr),
        .REG_ADDR_IN(addr), .REG_WDATA_IN(wdata), .REG_RDATA(rdata), .UART_IRQ(irq),
        .UART_SEND_BUSY_IN(busy), .UART_SEND_TRIGGER(trig), .UART_SEND_BYTE(sbyte),
        .UART_RECEIVED_IN(received), .UART_RECEIVE_BYTE_IN(rx_byte),
        .UART_RECEIVE_CAPTURE(capture)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watches trigger/capture edges away from the active edge; TX bytes are scored here.
    task automatic monitor_loop();
        logic trig_q, cap_q;
        logic [7:0] e;
        trig_q = 1'b0;
        cap_q  = 1'b0;
        forever begin
            @(negedge clk);
            if (trig && !trig_q) begin
                trig_count++;
                prev_trig = last_trig;
                last_trig = cyc;
                check("tx_pending", 32'(txq.size() != 0), 32'd1);
                if (txq.size() != 0) begin
                    e = txq.pop_front();
                    check("tx_byte", 32'(sbyte), 32'(e));
                end
            end
            if (capture && !cap_q) cap_count++;
            trig_q = trig;
            cap_q  = capture;
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; wdata = d;
        step();
        wr = 1'b0;
    endtask

    task automatic expect_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        rd = 1'b1; addr = a;
        step();
        rd = 1'b0;
        check(tag, 32'(rdata), 32'(exp));
    endtask

    task automatic expect_rx_data(input string tag);
        logic [7:0] e;
        e = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
        expect_reg(tag, 2'd0, e);
    endtask

    task automatic wait_trig(input int target, input int lim, input string tag);
        int k = 0;
        while (trig_count < target && k < lim) begin step(); k++; end
        check(tag, 32'(trig_count), 32'(target));
    endtask

    task automatic wait_cap(input int target, input int lim, input string tag);
        int k = 0;
        while (cap_count < target && k < lim) begin step(); k++; end
        check(tag, 32'(cap_count), 32'(target));
    endtask

    // Monitor-side model: present a byte until the port captures it.
    task automatic offer_rx(input logic [7:0] b);
        int base;
        base = cap_count;
        rx_byte = b; received = 1'b1;
        rxq.push_back(b);
        wait_cap(base + 1, 20, "rx_capture");
        received = 1'b0;
        repeat (8) step();
        check("rx_single_capture", 32'(cap_count), 32'(base + 1));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int base, rel, cbase;
        logic hit;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        busy = 1'b0; received = 1'b0; rx_byte = '0;
        repeat (3) step();
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_trig", 32'(trig), 32'h0);
        check("rst_sbyte", 32'(sbyte), 32'h0);
        check("rst_capture", 32'(capture), 32'h0);
        rst = 1'b0;
        fork monitor_loop(); join_none
        step();
        expect_reg("rst_stat", 2'd1, 8'h06);
        expect_reg("rst_rxcnt", 2'd2, 8'h00);
        expect_reg("rst_txcnt", 2'd3, 8'h00);

        // Two bytes, queued while busy then released
        busy = 1'b1;
        repeat (3) step();
        reg_write(2'd0, 8'h41); txq.push_back(8'h41);
        reg_write(2'd0, 8'h42); txq.push_back(8'h42);
        expect_reg("txcnt_2", 2'd3, 8'd2);
        busy = 1'b0;
        base = trig_count;
        wait_trig(base + 1, 20, "tx_first_edge");
        expect_reg("txcnt_1", 2'd3, 8'd1);
        wait_trig(base + 2, 30, "tx_second_edge");
        expect_reg("txcnt_0", 2'd3, 8'd0);
        check("tx_spacing", 32'((last_trig - prev_trig) >= 7), 32'd1);

        // Busy held high after the first strobe delays the second
        reg_write(2'd0, 8'h61); txq.push_back(8'h61);
        reg_write(2'd0, 8'h62); txq.push_back(8'h62);
        base = trig_count;
        wait_trig(base + 1, 20, "busy_first_edge");
        busy = 1'b1;
        repeat (50) step();
        check("busy_held", 32'(trig_count), 32'(base + 1));
        busy = 1'b0;
        rel = cyc;
        wait_trig(base + 2, 30, "busy_second_edge");
        check("busy_release_gap", 32'((last_trig - rel) >= 3), 32'd1);
        repeat (12) step();

        // Single RX byte
        offer_rx(8'h5A);
        expect_reg("rx_cnt_1", 2'd2, 8'd1);
        check("rx_irq_1", 32'(irq), 32'd1);
        expect_rx_data("rx_data_5a");
        check("rx_irq_0", 32'(irq), 32'd0);

        // TX overflow with busy stuck high
        busy = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 17; i++) begin
            reg_write(2'd0, 8'(8'h80 + i));
            if (i < 16) txq.push_back(8'(8'h80 + i));
        end
        expect_reg("txcnt_full", 2'd3, 8'd16);
        expect_reg("stat_txovf", 2'd1, 8'h10);
        reg_write(2'd1, 8'h10);
        expect_reg("stat_cleared", 2'd1, 8'h00);
        expect_reg("rx_empty_read", 2'd0, 8'h00);
        base = trig_count;
        busy = 1'b0;
        wait_trig(base + 16, 250, "tx_drain");
        repeat (12) step();
        check("txq_empty", 32'(txq.size()), 32'd0);
        expect_reg("txcnt_drained", 2'd3, 8'd0);

        // RX fill to full, then backpressure
        for (int i = 0; i < 16; i++) offer_rx(8'(8'hA0 + i));
        cbase = cap_count;
        rx_byte = 8'hB0; received = 1'b1;
        rxq.push_back(8'hB0);
        repeat (20) step();
        check("rx_stall_no_capture", 32'(cap_count), 32'(cbase));
        expect_reg("rx_cnt_full", 2'd2, 8'd16);
        expect_reg("stat_rxovf", 2'd1, 8'h0F);
        expect_rx_data("rx_data_first");
        wait_cap(cbase + 1, 20, "rx_17th_capture");
        received = 1'b0;
        repeat (8) step();
        for (int i = 0; i < 16; i++) expect_rx_data("rx_data_drain");
        expect_reg("rx_cnt_drained", 2'd2, 8'd0);
        check("rx_irq_drained", 32'(irq), 32'd0);

        // Reset while TX is in its guard window
        reg_write(2'd0, 8'h77); txq.push_back(8'h77);
        base = trig_count;
        wait_trig(base + 1, 20, "rst_tx_edge");
        expect_reg("stat_in_guard", 2'd1, 8'h0A);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_tx_trig", 32'(trig), 32'h0);
        check("rst_tx_sbyte", 32'(sbyte), 32'h0);
        check("rst_tx_rdata", 32'(rdata), 32'h0);
        repeat (30) step();
        check("rst_tx_no_edge", 32'(trig_count), 32'(base + 1));
        expect_reg("rst_tx_txcnt", 2'd3, 8'd0);

        // Reset while RX is strobing capture
        rx_byte = 8'h99; received = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (capture) hit = 1'b1;
        end
        check("rst_rx_strobe_seen", 32'(hit), 32'd1);
        rst = 1'b1; received = 1'b0;
        step();
        cbase = cap_count;
        rst = 1'b0;
        check("rst_rx_capture", 32'(capture), 32'h0);
        check("rst_rx_irq", 32'(irq), 32'h0);
        repeat (20) step();
        check("rst_rx_no_edge", 32'(cap_count), 32'(cbase));
        expect_reg("rst_rx_rxcnt", 2'd2, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
